// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: coin-operated vending controller with a configurable price.
// Accepts one coin per edge (quarter > dime > nickel), rejects extras and any
// coin offered while busy, delivers the product, then pays change as dimes
// while the dime tube has stock and nickels otherwise. All outputs are registered.
module vend_ctrl_param #(
  parameter int PRICE    = 5,
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                n,
  input  logic                d,
  input  logic                q,
  input  logic                cancel,
  input  logic                dime_empty,
  output logic                del,
  output logic                rd,
  output logic                rn,
  output logic                coin_rej,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] ZERO_C  = {CREDIT_W{1'b0}};
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO_C   = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] FIVE_C  = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CREDIT_W-1:0] credit_r;
  logic [CREDIT_W-1:0] credit_nxt_s;
  logic [CREDIT_W-1:0] change_r;
  logic [CREDIT_W-1:0] change_nxt_s;
  logic [CREDIT_W-1:0] coin_val_s;
  logic [CREDIT_W-1:0] sum_s;
  logic [CREDIT_W-1:0] dec_s;
  logic                any_coin_s;
  logic                multi_coin_s;
  logic                rej_nxt_s;
  logic                del_nxt_s;
  logic                rd_nxt_s;
  logic                rn_nxt_s;
  logic                busy_nxt_s;

  // Value of the single accepted coin, largest denomination wins.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic cn, input logic cd,
                                                      input logic cq);
    logic [CREDIT_W-1:0] v;
    if (cq) begin
      v = FIVE_C;
    end else if (cd) begin
      v = TWO_C;
    end else if (cn) begin
      v = ONE_C;
    end else begin
      v = ZERO_C;
    end
    return v;
  endfunction

  // Coin decode: selected value, presence, and whether more than one coin arrived.
  always_comb begin
    coin_val_s   = coin_value(n, d, q);
    any_coin_s   = n | d | q;
    multi_coin_s = (n & d) | (n & q) | (d & q);
    sum_s        = credit_r + coin_val_s;
    // The step taken must match the coin actually being paid out this cycle.
    dec_s        = rd ? TWO_C : ONE_C;
  end

  // Next-state, credit/change update and coin rejection.
  always_comb begin
    state_nxt_s  = state_r;
    credit_nxt_s = credit_r;
    change_nxt_s = change_r;
    rej_nxt_s    = 1'b0;
    case (state_r)
      ACCUM: begin
        if (cancel && (credit_r != ZERO_C)) begin
          change_nxt_s = credit_r;
          credit_nxt_s = ZERO_C;
          state_nxt_s  = CHANGE;
          rej_nxt_s    = any_coin_s;
        end else if (any_coin_s) begin
          rej_nxt_s = multi_coin_s;
          if (sum_s >= PRICE_C) begin
            credit_nxt_s = ZERO_C;
            change_nxt_s = sum_s - PRICE_C;
            state_nxt_s  = VEND;
          end else begin
            credit_nxt_s = sum_s;
            state_nxt_s  = ACCUM;
          end
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      VEND: begin
        rej_nxt_s = any_coin_s;
        if (change_r != ZERO_C) begin
          state_nxt_s = CHANGE;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      CHANGE: begin
        rej_nxt_s = any_coin_s;
        // Saturate at zero so a corrupted change value cannot wrap around.
        if (change_r > dec_s) begin
          change_nxt_s = change_r - dec_s;
          state_nxt_s  = CHANGE;
        end else begin
          change_nxt_s = ZERO_C;
          state_nxt_s  = ACCUM;
        end
      end
      default: begin
        state_nxt_s  = ACCUM;
        credit_nxt_s = ZERO_C;
        change_nxt_s = ZERO_C;
        rej_nxt_s    = 1'b0;
      end
    endcase
  end

  // Output decode for the coming cycle from the next state and remaining change.
  always_comb begin
    del_nxt_s  = (state_nxt_s == VEND);
    busy_nxt_s = (state_nxt_s != ACCUM);
    rd_nxt_s   = (state_nxt_s == CHANGE) && (change_nxt_s >= TWO_C) && !dime_empty;
    rn_nxt_s   = (state_nxt_s == CHANGE) && !rd_nxt_s;
  end

  // State, credit, change and registered outputs; reset discards any pending payout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ACCUM;
      credit_r <= ZERO_C;
      change_r <= ZERO_C;
      del      <= 1'b0;
      rd       <= 1'b0;
      rn       <= 1'b0;
      coin_rej <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      credit_r <= credit_nxt_s;
      change_r <= change_nxt_s;
      del      <= del_nxt_s;
      rd       <= rd_nxt_s;
      rn       <= rn_nxt_s;
      coin_rej <= rej_nxt_s;
      busy     <= busy_nxt_s;
    end
  end

  assign credit = credit_r;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Testbench for vend_ctrl_param: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural model, for PRICE=5 and 7.
module tb_vend_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, n, d, q, cancel, dime_empty;
  logic del5, rd5, rn5, rej5, busy5;
  logic del7, rd7, rn7, rej7, busy7;
  logic [5:0] credit5, credit7;

  vend_ctrl_param #(.PRICE(5), .CREDIT_W(6)) dut5 (
    .clk(clk), .rst(rst), .n(n), .d(d), .q(q), .cancel(cancel), .dime_empty(dime_empty),
    .del(del5), .rd(rd5), .rn(rn5), .coin_rej(rej5), .busy(busy5), .credit(credit5));

  vend_ctrl_param #(.PRICE(7), .CREDIT_W(6)) dut7 (
    .clk(clk), .rst(rst), .n(n), .d(d), .q(q), .cancel(cancel), .dime_empty(dime_empty),
    .del(del7), .rd(rd7), .rn(rn7), .coin_rej(rej7), .busy(busy7), .credit(credit7));

  int total = 0;
  int bad   = 0;

  // Behavioural model: money held as credit, a pending delivery flag, and an amount owed.
  int m_credit[2];
  int m_owed[2];
  bit m_del[2];
  bit m_rd[2];
  bit m_rn[2];
  bit m_rej[2];
  int m_acc[2];
  int c_del[2];
  int c_rd[2];
  int c_rn[2];

  typedef struct {
    logic rst, n, d, q, c, de;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic int price_of(int i);
    return (i == 0) ? 5 : 7;
  endfunction

  function automatic logic [10:0] pk(logic a, logic b, logic c, logic e, logic f, logic [5:0] cr);
    return {a, b, c, e, f, cr};
  endfunction

  function automatic vec_t mk(logic r, logic cn, logic cd, logic cq, logic cc, logic de,
                              logic edel, logic erd, logic ern, logic erej, logic ebusy,
                              int cr);
    vec_t v;
    v.rst = r; v.n = cn; v.d = cd; v.q = cq; v.c = cc; v.de = de;
    v.exp = pk(edel, erd, ern, erej, ebusy, 6'(cr));
    return v;
  endfunction

  function automatic void model_step(int i);
    int v;
    bit anyc;
    bit multi;
    anyc  = n | d | q;
    multi = (int'(n) + int'(d) + int'(q)) > 1;
    if (rst) begin
      m_credit[i] = 0; m_owed[i] = 0; m_del[i] = 1'b0;
      m_rd[i] = 1'b0; m_rn[i] = 1'b0; m_rej[i] = 1'b0;
      m_acc[i] = 0; c_del[i] = 0; c_rd[i] = 0; c_rn[i] = 0;
    end else begin
      m_rej[i] = 1'b0;
      if (m_del[i] || m_owed[i] > 0) begin
        m_rej[i] = anyc;
        if (m_del[i]) m_del[i] = 1'b0;
        else m_owed[i] -= m_rd[i] ? 2 : 1;
      end else if (cancel && m_credit[i] > 0) begin
        m_owed[i] = m_credit[i];
        m_credit[i] = 0;
        m_rej[i] = anyc;
      end else if (anyc) begin
        v = q ? 5 : (d ? 2 : 1);
        m_rej[i] = multi;
        m_acc[i] += v;
        m_credit[i] += v;
        if (m_credit[i] >= price_of(i)) begin
          m_owed[i] = m_credit[i] - price_of(i);
          m_credit[i] = 0;
          m_del[i] = 1'b1;
        end
      end
      m_rd[i] = !m_del[i] && m_owed[i] >= 2 && !dime_empty;
      m_rn[i] = !m_del[i] && m_owed[i] > 0 && !m_rd[i];
    end
  endfunction

  function automatic logic [10:0] model_pk(int i);
    return pk(m_del[i], m_rd[i], m_rn[i], m_rej[i], m_del[i] || (m_owed[i] > 0),
              6'(m_credit[i]));
  endfunction

  task automatic chk(string name, logic [10:0] act, logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got del/rd/rn/rej/busy/credit=%b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%0d",
               name, act[10], act[9], act[8], act[7], act[6], act[5:0],
               exp[10], exp[9], exp[8], exp[7], exp[6], exp[5:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    c_del[0] += int'(del5); c_rd[0] += int'(rd5); c_rn[0] += int'(rn5);
    c_del[1] += int'(del7); c_rd[1] += int'(rd7); c_rn[1] += int'(rn7);
    chk("model_p5", pk(del5, rd5, rn5, rej5, busy5, credit5), model_pk(0));
    chk("model_p7", pk(del7, rd7, rn7, rej7, busy7, credit7), model_pk(1));
  endtask

  task automatic drive(logic r, logic cn, logic cd, logic cq, logic cc, logic de);
    rst = r; n = cn; d = cd; q = cq; cancel = cc; dime_empty = de;
  endtask

  task automatic conserve(string name, int i, logic [5:0] cr);
    total++;
    if (m_acc[i] != c_del[i] * price_of(i) + 2 * c_rd[i] + c_rn[i] + int'(cr)) begin
      bad++;
      $display("FAIL %s: accepted=%0d paid out del=%0d rd=%0d rn=%0d credit=%0d",
               name, m_acc[i], c_del[i], c_rd[i], c_rn[i], cr);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_credit[i] = 0; m_owed[i] = 0; m_del[i] = 1'b0; m_rd[i] = 1'b0; m_rn[i] = 1'b0;
      m_rej[i] = 1'b0; m_acc[i] = 0; c_del[i] = 0; c_rd[i] = 0; c_rn[i] = 0;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    //            rst n d q c de   del rd rn rej busy credit   (PRICE=5)
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));  // reset
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1, 0));  // q -> deliver
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 2));  // d
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 4));  // d
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1, 0));  // q, change 4
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 2));  // dimes empty
    tbl.push_back(mk(0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1,  1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));  // n
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 3));  // d
    tbl.push_back(mk(0, 0, 1, 0, 1, 0,  0, 1, 0, 1, 1, 0));  // cancel + d
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0,  1, 0, 0, 1, 1, 0));  // n,d,q together
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1, 0));  // change 2
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0));  // d during CHANGE
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 1, 0));  // refund 4
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1, 0));  // second rd
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));  // reset mid-change
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1));  // cancel at credit 0
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 1, 0));  // refund 1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].c, tbl[i].de);
      tick();
      chk($sformatf("vec%0d", i), pk(del5, rd5, rn5, rej5, busy5, credit5), tbl[i].exp);
    end

    // PRICE=7: seven nickels deliver on the seventh with no change.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 7; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      if (k < 7) chk($sformatf("p7_nickel%0d", k), pk(del7, rd7, rn7, rej7, busy7, credit7),
                     pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'(k)));
      else       chk("p7_deliver", pk(del7, rd7, rn7, rej7, busy7, credit7),
                     pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("p7_idle", pk(del7, rd7, rn7, rej7, busy7, credit7),
        pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));

    // Randomized traffic checked against the model every cycle.
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 249) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 11) == 0,
            ($urandom_range(0, 29) == 0) ? ~dime_empty : dime_empty);
      tick();
    end

    // Drain any payout in progress, then check value conservation.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, dime_empty);
    for (int k = 0; k < 8; k++) tick();
    total++;
    if (busy5 || busy7) begin
      bad++;
      $display("FAIL drain: busy5=%b busy7=%b expected 0/0 after 8 idle cycles", busy5, busy7);
    end
    conserve("conserve_p5", 0, credit5);
    conserve("conserve_p7", 1, credit7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
